serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial-to-parallel frame receiver for the bitstream that the shift-register datapath drives out of its serial end, one bit per accepted cycle. It assembles WIDTH-bit words in MSB-first or LSB-first order. Each finished word goes into a one-entry output buffer and is handed off with a valid/ready handshake. Overrun is reported, and an optional even-parity bit is checked.

## Interface
- WIDTH, default 4, data bits per frame (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- bit_valid  input  1  serial_din carries a bit this cycle
- serial_din  input  1  serial data bit
- frame_start  input  1  qualifies the current bit as the first bit of a frame (ignored unless bit_valid)
- msb_first  input  1  bit order, sampled with the first bit: 1 = MSB first, 0 = LSB first
- parallel_dout  output  WIDTH  received word
- dout_valid  output  1  parallel_dout holds an unconsumed word
- dout_ready  input  1  consumer accepts the word
- busy  output  1  frame in progress (state ≠ IDLE)
- overrun  output  1  one-cycle pulse: a completed word was dropped
- parity_err  output  1  parity mismatch for the word in parallel_dout; constant 0 without parity

## Operation
- FSM states: IDLE, SHIFT, PARITY (parity build only).
- IDLE:
  - bit_valid && frame_start: capture the bit, latch msb_first, count = 1, go to SHIFT.
  - Any other bits are ignored.
- SHIFT, on each bit_valid:
  - MSB first: sreg <= {sreg[WIDTH-2:0], din}.
  - LSB first: sreg <= {din, sreg[WIDTH-1:1]}.
  - count increments. On the WIDTH-th bit, go to PARITY (parity build) or complete and return to IDLE.
- PARITY: the next bit_valid is the parity bit. Complete, return to IDLE.
- No bit_valid: no state or count change (stall of any length).
- bit_valid && frame_start in SHIFT/PARITY:
  - Partial frame is discarded silently.
  - The bit becomes bit 1 of a new frame; order is re-latched.
- Completion, with the buffer free (dout_valid == 0, or dout_valid && dout_ready that cycle):
  - The word loads into parallel_dout.
  - dout_valid <= 1, and parity_err is updated.
- Completion with the buffer full and not draining:
  - The word is dropped and overrun pulses for 1 cycle.
  - parallel_dout, dout_valid and parity_err are unchanged.
- dout_valid && dout_ready with no completion: dout_valid <= 0. parallel_dout keeps its last value.
- The shift register is independent of the output buffer, so a new frame may be received while a word is pending.
- Reset (any time, including mid-frame):
  - State IDLE, count 0, sreg 0.
  - parallel_dout = 0, dout_valid = 0, busy = 0, overrun = 0, parity_err = 0.

## Timing
- Latency: dout_valid rises on the edge that samples the final bit of the frame (the last data bit, or the parity bit), i.e. visible the cycle after that bit is presented.
- Back-to-back frames with no gap are supported at full rate, one bit per clock.
- parallel_dout and parity_err are stable while dout_valid && !dout_ready.
- A word is consumed on the edge where dout_valid && dout_ready.
- busy:
  - Asserts the cycle after the first bit is accepted.
  - Deasserts the cycle after completion, unless that completing cycle also carries frame_start.
- overrun is registered and appears on the cycle after the dropping edge.

## Configuration
- SIPO_PARITY_EN defined:
  - Each frame is WIDTH data bits followed by one even-parity bit; the PARITY state exists.
  - parity_err = XOR(data, parity bit) for the delivered word.
  - A word with bad parity is still delivered.
- Not defined:
  - Frames are WIDTH bits and there is no PARITY state.
  - parity_err is tied to 0.

## Test plan
- WIDTH=4, LSB first, bits 1,0,1,1 with frame_start on the first, dout_ready=1 → parallel_dout=4'b1101, dout_valid high for exactly 1 cycle, 1 clock after the 4th bit.
- MSB first, bits 1,0,1,1 with random bit_valid gaps (0–3 cycles) → parallel_dout=4'b1011; busy high from the 1st bit through completion.
- dout_ready=0, frames 4'hA then 4'h5 back-to-back → 4'hA held, overrun pulses once at the 2nd completion. Repeat with dout_ready=1 on that completion edge → no overrun, 4'h5 loaded.
- frame_start reasserted after 2 bits, then 4 bits 0,1,1,0 MSB first → single word 4'b0110. Reset asserted mid-frame → all outputs 0 immediately, and the next frame decodes correctly.
- SIPO_PARITY_EN, data 1,1,0,1 MSB first + parity 1 → 4'b1101, parity_err=0. Same frame with parity 0 → parity_err=1, word still delivered.

Source files
------------

// File: rtl/serial_word_rx.sv
// Serial-to-parallel frame receiver: assembles WIDTH-bit words MSB/LSB first into a
// one-entry valid/ready output buffer. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module serial_word_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             serial_din,
    input  logic             frame_start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] parallel_dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_sreg;
    logic             r_msb;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;

    logic             w_start;
    logic             w_last;
    logic             w_done;
    logic             w_free;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_word;

    assign w_start = bit_valid && frame_start;
    assign w_last  = (r_count == CW'(WIDTH - 1));
    assign w_free  = !r_dout_valid || dout_ready;
    assign w_first = msb_first ? {{(WIDTH-1){1'b0}}, serial_din} : {serial_din, {(WIDTH-1){1'b0}}};
    assign w_next  = r_msb ? {r_sreg[WIDTH-2:0], serial_din} : {serial_din, r_sreg[WIDTH-1:1]};

`ifdef SIPO_PARITY_EN
    logic w_perr;
    logic r_perr;
    // The word is already complete in sreg; the parity bit only finishes the frame.
    assign w_done     = (r_state == PARITY) && bit_valid && !frame_start;
    assign w_word     = r_sreg;
    assign w_perr     = (^r_sreg) ^ serial_din;
    assign parity_err = r_perr;
`else
    assign w_done     = (r_state == SHIFT) && bit_valid && !frame_start && w_last;
    assign w_word     = w_next;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_sreg       <= '0;
            r_msb        <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
            r_perr       <= 1'b0;
`endif
        end else begin
            r_overrun <= 1'b0;

            // A frame_start bit restarts reception from any state, dropping a partial frame.
            if (w_start) begin
                r_sreg  <= w_first;
                r_msb   <= msb_first;
                r_count <= CW'(1);
                r_state <= SHIFT;
            end else if (bit_valid) begin
                case (r_state)
                    SHIFT: begin
                        r_sreg  <= w_next;
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_count <= '0;
`ifdef SIPO_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= IDLE;
`endif
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PARITY: begin
                        r_count <= '0;
                        r_state <= IDLE;
                    end
`endif
                    default: ;
                endcase
            end

            if (w_done) begin
                if (w_free) begin
                    r_dout       <= w_word;
                    r_dout_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                    r_perr       <= w_perr;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign parallel_dout = r_dout;
    assign dout_valid    = r_dout_valid;
    assign overrun       = r_overrun;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed self-checking bench for serial_word_rx (WIDTH=4); parity cases run when
// SIPO_PARITY_EN is defined.
module tb_serial_word_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       serial_din;
    logic       frame_start;
    logic       msb_first;
    logic [3:0] parallel_dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int n_tests = 0;
    int n_fail  = 0;

    serial_word_rx #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_valid    (bit_valid),
        .serial_din   (serial_din),
        .frame_start  (frame_start),
        .msb_first    (msb_first),
        .parallel_dout(parallel_dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .busy         (busy),
        .overrun      (overrun),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one cycle of input, then let it be sampled; outputs are read 1 unit later.
    task automatic step(input logic bv, input logic d, input logic fs);
        bit_valid   = bv;
        serial_din  = d;
        frame_start = fs;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // Sends a whole frame MSB first (msb_first must be 1); dout_ready = rdy_last on the final bit.
    task automatic send_word(input logic [3:0] w, input logic rdy_last);
        for (int i = 0; i < 4; i++) begin
`ifndef SIPO_PARITY_EN
            if (i == 3) dout_ready = rdy_last;
`endif
            step(1'b1, w[3-i], i == 0);
        end
`ifdef SIPO_PARITY_EN
        dout_ready = rdy_last;
        step(1'b1, ^w, 1'b0);
`endif
    endtask

    initial begin
        rst = 1'b1; bit_valid = 0; serial_din = 0; frame_start = 0;
        msb_first = 0; dout_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",  parallel_dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_ovr",   overrun, 0);
        chk("rst_perr",  parity_err, 0);
        rst = 1'b0;
        step(0, 0, 0);

        // LSB first 1,0,1,1 -> 4'b1101, valid for one cycle
        dout_ready = 1; msb_first = 0;
        step(1, 1, 1);
        chk("t1_busy1", busy, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
`ifdef SIPO_PARITY_EN
        chk("t1_noval_pre_par", dout_valid, 0);
        step(1, 1, 0);
`endif
        chk("t1_valid", dout_valid, 1);
        chk("t1_dout",  parallel_dout, 4'b1101);
        chk("t1_busy0", busy, 0);
        chk("t1_perr",  parity_err, 0);
        step(0, 0, 0);
        chk("t1_valid_1cyc", dout_valid, 0);

        // MSB first 1,0,1,1 with stalls -> 4'b1011
        msb_first = 1;
        step(1, 1, 1);
        msb_first = 0;
        step(0, 0, 0); step(0, 0, 0);
        chk("t2_busy_gap", busy, 1);
        step(1, 0, 0);
        step(1, 1, 0);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("t2_busy_gap2", busy, 1);
        chk("t2_noval", dout_valid, 0);
        step(1, 1, 0);
`ifdef SIPO_PARITY_EN
        step(0, 0, 0);
        step(1, 1, 0);
`endif
        chk("t2_valid", dout_valid, 1);
        chk("t2_dout",  parallel_dout, 4'b1011);
        chk("t2_busy0", busy, 0);
        step(0, 0, 0);

        // Back-to-back frames into a full buffer -> overrun, A held
        msb_first = 1; dout_ready = 0;
        send_word(4'hA, 0);
        chk("t3_valA", dout_valid, 1);
        chk("t3_doutA", parallel_dout, 4'hA);
        chk("t3_ovr0", overrun, 0);
        send_word(4'h5, 0);
        chk("t3_ovr1", overrun, 1);
        chk("t3_hold", parallel_dout, 4'hA);
        chk("t3_val_hold", dout_valid, 1);
        step(0, 0, 0);
        chk("t3_ovr_pulse", overrun, 0);
        dout_ready = 1;
        step(0, 0, 0);
        chk("t3_consumed", dout_valid, 0);
        dout_ready = 0;
        send_word(4'hA, 0);
        send_word(4'h5, 1);
        chk("t3b_ovr", overrun, 0);
        chk("t3b_dout5", parallel_dout, 4'h5);
        chk("t3b_val", dout_valid, 1);
        step(0, 0, 0);
        chk("t3b_drain", dout_valid, 0);

        // Restart after 2 bits, then 0,1,1,0 MSB first -> single word 4'b0110
        dout_ready = 1; msb_first = 1;
        step(1, 1, 1);
        step(1, 1, 0);
        step(1, 0, 1);
        step(1, 1, 0);
        chk("t4_nopartial", dout_valid, 0);
        step(1, 1, 0);
        chk("t4_noval3", dout_valid, 0);
        step(1, 0, 0);
`ifdef SIPO_PARITY_EN
        step(1, 0, 0);
`endif
        chk("t4_val", dout_valid, 1);
        chk("t4_dout", parallel_dout, 4'b0110);
        step(0, 0, 0);

        // Asynchronous reset mid-frame with a word pending
        dout_ready = 0;
        send_word(4'h9, 0);
        chk("t5_pre_val", dout_valid, 1);
        step(1, 1, 1);
        step(1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_dout",  parallel_dout, 0);
        chk("t5_rst_valid", dout_valid, 0);
        chk("t5_rst_busy",  busy, 0);
        chk("t5_rst_ovr",   overrun, 0);
        chk("t5_rst_perr",  parity_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dout_ready = 1; msb_first = 0;
        step(1, 1, 1);
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
`ifdef SIPO_PARITY_EN
        step(1, 0, 0);
`endif
        chk("t5_val", dout_valid, 1);
        chk("t5_dout", parallel_dout, 4'b0011);
        step(0, 0, 0);

`ifdef SIPO_PARITY_EN
        // Even parity: 1101 + parity 1 is good, + parity 0 is flagged but delivered
        msb_first = 1; dout_ready = 1;
        step(1, 1, 1); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        chk("p1_wait_par", dout_valid, 0);
        step(1, 1, 0);
        chk("p1_val", dout_valid, 1);
        chk("p1_dout", parallel_dout, 4'b1101);
        chk("p1_perr", parity_err, 0);
        step(0, 0, 0);
        step(1, 1, 1); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        step(1, 0, 0);
        chk("p2_val", dout_valid, 1);
        chk("p2_dout", parallel_dout, 4'b1101);
        chk("p2_perr", parity_err, 1);
        step(0, 0, 0);
`else
        chk("np_perr", parity_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
